// File: rtl/instruction_encoder_pkg.sv
// Shared types for the instruction encoder: opcodes, formats,
// immediate limits and the field-level request bundle.
package instruction_encoder_pkg;

    typedef logic [31:0]        word_t;
    typedef logic signed [31:0] signed_word_t;
    typedef logic [4:0]         register_index_t;
    typedef logic [2:0]         funct3_t;
    typedef logic [6:0]         funct7_t;

    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'h03,
        OPCODE_OP_IMM = 7'h13,
        OPCODE_AUIPC  = 7'h17,
        OPCODE_STORE  = 7'h23,
        OPCODE_OP     = 7'h33,
        OPCODE_LUI    = 7'h37,
        OPCODE_BRANCH = 7'h63,
        OPCODE_JALR   = 7'h67,
        OPCODE_JAL    = 7'h6f,
        OPCODE_SYSTEM = 7'h73
    } base_opcode_t;

    localparam funct3_t F3_SLL     = 3'b001;
    localparam funct3_t F3_SRL_SRA = 3'b101;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } fmt_t;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;
    localparam int SHAMT_MAX = 31;

    typedef struct packed {
        base_opcode_t    opcode;
        funct3_t         funct3;
        funct7_t         funct7;
        register_index_t rd;
        register_index_t rs1;
        register_index_t rs2;
        signed_word_t    imm;
    } encode_request_t;

    function automatic logic in_range(signed_word_t v, int lo, int hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic fmt_t fmt_of(base_opcode_t op);
        fmt_t f;
        unique case (op)
            OPCODE_OP:     f = FMT_R;
            OPCODE_OP_IMM: f = FMT_I;
            OPCODE_LOAD:   f = FMT_I;
            OPCODE_JALR:   f = FMT_I;
            OPCODE_SYSTEM: f = FMT_I;
            OPCODE_STORE:  f = FMT_S;
            OPCODE_BRANCH: f = FMT_B;
            OPCODE_LUI:    f = FMT_U;
            OPCODE_AUIPC:  f = FMT_U;
            OPCODE_JAL:    f = FMT_J;
            default:       f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instruction_encoder_packer.sv
// Combinational packer: request fields to a 32-bit RV32I word,
// plus a flag telling whether the immediate fits the format.
module instruction_packer
    import instruction_encoder_pkg::*;
(
    input  encode_request_t req,
    output word_t           word,
    output logic            encodable
);

    fmt_t         fmt;
    signed_word_t imm;
    logic         is_shift;

    always_comb begin
        fmt       = fmt_of(req.opcode);
        imm       = req.imm;
        is_shift  = (req.opcode == OPCODE_OP_IMM) &&
                    ((req.funct3 == F3_SLL) ||
                     (req.funct3 == F3_SRL_SRA));
        word      = '0;
        encodable = 1'b0;
        unique case (fmt)
            FMT_R: begin
                word = {req.funct7, req.rs2, req.rs1,
                        req.funct3, req.rd, req.opcode};
                encodable = 1'b1;
            end
            FMT_I: begin
                if (is_shift) begin
                    // shamt lives in the rs2 slot, funct7 selects SRL/SRA
                    word = {req.funct7, imm[4:0], req.rs1,
                            req.funct3, req.rd, req.opcode};
                    encodable = in_range(imm, 0, SHAMT_MAX);
                end else begin
                    word = {imm[11:0], req.rs1,
                            req.funct3, req.rd, req.opcode};
                    encodable = in_range(imm, IMM_I_MIN, IMM_I_MAX);
                end
            end
            FMT_S: begin
                word = {imm[11:5], req.rs2, req.rs1,
                        req.funct3, imm[4:0], req.opcode};
                encodable = in_range(imm, IMM_I_MIN, IMM_I_MAX);
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], req.rs2, req.rs1,
                        req.funct3, imm[4:1], imm[11], req.opcode};
                encodable = in_range(imm, IMM_B_MIN, IMM_B_MAX) &&
                            !imm[0];
            end
            FMT_U: begin
                word = {imm[31:12], req.rd, req.opcode};
                encodable = (imm[11:0] == 12'h000);
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12],
                        req.rd, req.opcode};
                encodable = in_range(imm, IMM_J_MIN, IMM_J_MAX) &&
                            !imm[0];
            end
            default: begin
                word      = '0;
                encodable = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Request/write FSM: accepts field requests, writes packed words
// to consecutive addresses, counts writes, flags rejects.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   base_load,
    input  logic [31:0]            base_address,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [6:0]             req_opcode,
    input  logic [2:0]             req_funct3,
    input  logic [6:0]             req_funct7,
    input  logic [4:0]             req_rd,
    input  logic [4:0]             req_rs1,
    input  logic [4:0]             req_rs2,
    input  logic [31:0]            req_imm,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [31:0]            mem_address,
    output logic [3:0]             mem_wstrobe,
    output logic [31:0]            mem_wdata,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] word_count
);

    typedef enum logic {
        ST_READY,
        ST_WRITE
    } state_t;

    state_t          state;
    encode_request_t req;
    word_t           packed_word;
    logic            encodable;

    assign req = '{
        opcode: base_opcode_t'(req_opcode),
        funct3: req_funct3,
        funct7: req_funct7,
        rd:     req_rd,
        rs1:    req_rs1,
        rs2:    req_rs2,
        imm:    req_imm
    };

    instruction_packer u_packer (
        .req       (req),
        .word      (packed_word),
        .encodable (encodable)
    );

    // base_load wins over a request, so hide ready while it is high
    assign req_ready   = (state == ST_READY) && !base_load;
    assign mem_wstrobe = mem_valid ? 4'hf : 4'h0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_READY;
            mem_address <= '0;
            mem_valid   <= 1'b0;
            mem_wdata   <= '0;
            error       <= 1'b0;
            word_count  <= '0;
        end else begin
            unique case (state)
                ST_READY: begin
                    if (base_load) begin
                        mem_address <= base_address & 32'hffff_fffc;
                    end else if (req_valid) begin
                        if (encodable) begin
                            mem_wdata <= packed_word;
                            mem_valid <= 1'b1;
                            state     <= ST_WRITE;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) begin
                        mem_valid   <= 1'b0;
                        mem_address <= mem_address + 32'd4;
                        word_count  <= word_count + 1'b1;
                        state       <= ST_READY;
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed and random
// requests checked against an arithmetic RV32I reference model.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        base_load = 1'b0;
    logic [31:0] base_address = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_opcode = '0;
    logic [2:0]  req_funct3 = '0;
    logic [6:0]  req_funct7 = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_address;
    logic [3:0]  mem_wstrobe;
    logic [31:0] mem_wdata;
    logic        error;
    logic [15:0] word_count;

    instruction_encoder #(.COUNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .base_load    (base_load),
        .base_address (base_address),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_funct3   (req_funct3),
        .req_funct7   (req_funct7),
        .req_rd       (req_rd),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_address  (mem_address),
        .mem_wstrobe  (mem_wstrobe),
        .mem_wdata    (mem_wdata),
        .error        (error),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_addr = '0;
    int          exp_count = 0;
    logic        exp_error = 1'b0;
    bit          rnd_ready = 1'b0;
    bit          hold = 1'b0;
    logic [31:0] hold_a, hold_d;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic void ref_model(
        input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [31:0] imm,
        output bit ok, output logic [31:0] w);
        int s;
        logic [31:0] u, regs;
        s = int'(imm);
        u = imm;
        regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
        ok = 0;
        w = 0;
        case (op)
            7'h33: begin
                ok = 1;
                w = (32'(f7) << 25) | regs | (32'(rd) << 7) | 32'(op);
            end
            7'h13, 7'h03, 7'h67, 7'h73: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    ok = (s >= 0 && s <= 31);
                    w = (32'(f7) << 25) | ((u % 32) << 20);
                end else begin
                    ok = (s >= -2048 && s <= 2047);
                    w = (u % 4096) << 20;
                end
                w = w | (32'(rs1) << 15) | (32'(f3) << 12)
                      | (32'(rd) << 7) | 32'(op);
            end
            7'h23: begin
                ok = (s >= -2048 && s <= 2047);
                w = (((u / 32) % 128) << 25) | regs
                  | ((u % 32) << 7) | 32'(op);
            end
            7'h63: begin
                ok = (s >= -4096 && s <= 4094) && (s % 2 == 0);
                w = (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25)
                  | regs | (((u / 2) % 16) << 8)
                  | (((u / 2048) % 2) << 7) | 32'(op);
            end
            7'h37, 7'h17: begin
                ok = (u % 4096 == 0);
                w = (u - (u % 4096)) | (32'(rd) << 7) | 32'(op);
            end
            7'h6f: begin
                ok = (s >= -1048576 && s <= 1048574) && (s % 2 == 0);
                w = (((u / 1048576) % 2) << 31)
                  | (((u / 2) % 1024) << 21)
                  | (((u / 2048) % 2) << 20)
                  | (((u / 4096) % 256) << 12)
                  | (32'(rd) << 7) | 32'(op);
            end
            default: ok = 0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) mem_ready = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("word_count", 32'(word_count),
                  32'(exp_count % 65536));
            check("error", 32'(error), 32'(exp_error));
            if (hold) begin
                check("hold_valid", 32'(mem_valid), 1);
                check("hold_addr", mem_address, hold_a);
                check("hold_data", mem_wdata, hold_d);
            end
            hold = 0;
            if (mem_valid) begin
                check("wstrobe", 32'(mem_wstrobe), 32'hf);
                if (mem_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_write", 32'(mem_valid), 0);
                    end else begin
                        e = q.pop_front();
                        check("mem_address", mem_address, e.a);
                        check("mem_wdata", mem_wdata, e.d);
                        exp_count++;
                    end
                end else begin
                    hold = 1;
                    hold_a = mem_address;
                    hold_d = mem_wdata;
                end
            end else begin
                check("wstrobe_idle", 32'(mem_wstrobe), 0);
            end
        end
    end

    task automatic send(logic [6:0] op, logic [2:0] f3,
                        logic [6:0] f7, logic [4:0] rd,
                        logic [4:0] rs1, logic [4:0] rs2,
                        logic [31:0] imm, bit use_exp,
                        logic [31:0] exp_w);
        bit ok;
        logic [31:0] w;
        int n = 0;
        @(posedge clk);
        #1;
        req_opcode = op;
        req_funct3 = f3;
        req_funct7 = f7;
        req_rd = rd;
        req_rs1 = rs1;
        req_rs2 = rs2;
        req_imm = imm;
        req_valid = 1;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            check("req_ready_timeout", 32'(req_ready), 1);
            req_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 0;
        ref_model(op, f3, f7, rd, rs1, rs2, imm, ok, w);
        if (use_exp) begin
            ok = 1;
            w = exp_w;
        end
        if (ok) begin
            q.push_back('{a: exp_addr, d: w});
            exp_addr = exp_addr + 32'd4;
        end else begin
            exp_error = 1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!mem_valid && q.size() == 0) break;
            n++;
            if (n > 500) break;
        end
        if (n > 500) check("idle_timeout", 32'(q.size()), 0);
    endtask

    task automatic load_base(logic [31:0] a);
        wait_idle();
        @(posedge clk);
        #1;
        base_load = 1;
        base_address = a;
        @(negedge clk);
        check("ready_during_load", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        base_load = 0;
        exp_addr = a & 32'hffff_fffc;
    endtask

    task automatic rand_req();
        logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
                                 7'h37, 7'h63, 7'h67, 7'h6f, 7'h73,
                                 7'h7f};
        logic [6:0] op;
        logic [2:0] f3;
        logic [31:0] imm;
        op = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 19) == 0) op = 7'($urandom);
        f3 = 3'($urandom);
        case (op)
            7'h63: imm = 32'($urandom_range(0, 8400)) - 32'd4200;
            7'h6f: imm = 32'($urandom_range(0, 2200000)) - 32'd1100000;
            7'h37, 7'h17: imm = {$urandom_range(0, 1048575) > 0 ?
                                 20'($urandom) : 20'h0, 12'h0};
            default: imm = 32'($urandom_range(0, 4200)) - 32'd2100;
        endcase
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5))
            imm = 32'($urandom_range(0, 40));
        if ($urandom_range(0, 9) == 0) imm = $urandom;
        send(op, f3, 7'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), imm, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_address", mem_address, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_req_ready", 32'(req_ready), 1);

        load_base(32'h0000_1003);
        send(7'h13, 0, 0, 1, 0, 0, 5, 1, 32'h0050_0093);
        wait_idle();
        check("count_after_addi", 32'(word_count), 1);

        load_base(32'h1000);
        send(7'h23, 2, 0, 0, 1, 2, 8, 1, 32'h0020_a423);
        send(7'h63, 0, 0, 0, 0, 0, -32'sd4, 1, 32'hfe00_0ee3);
        send(7'h37, 0, 0, 5, 0, 0, 32'h1234_5000, 1, 32'h1234_52b7);
        send(7'h6f, 0, 0, 1, 0, 0, 2048, 1, 32'h0010_00ef);
        wait_idle();

        mem_ready = 0;
        send(7'h13, 0, 0, 3, 4, 0, -32'sd7, 1, 32'hff92_0193);
        base_load = 1;
        base_address = 32'hdead_0000;
        repeat (3) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_addr", mem_address, exp_addr - 32'd4);
        end
        @(posedge clk);
        #1;
        base_load = 0;
        mem_ready = 1;
        wait_idle();

        send(7'h13, 0, 0, 1, 0, 0, 2048, 0, 0);
        @(negedge clk);
        check("reject_error", 32'(error), 1);
        send(7'h63, 0, 0, 0, 0, 0, 3, 0, 0);
        send(7'h7f, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("reject_addr", mem_address, exp_addr);
        send(7'h33, 0, 7'h20, 3, 1, 2, 0, 1, 32'h4020_81b3);
        wait_idle();

        rnd_ready = 1;
        for (int i = 0; i < 300; i++) rand_req();
        rnd_ready = 0;
        mem_ready = 1;
        wait_idle();

        load_base(32'hffff_fffc);
        send(7'h13, 1, 7'h00, 2, 2, 0, 31, 1, 32'h01f1_1113);
        send(7'h13, 5, 7'h20, 2, 2, 0, 4, 1, 32'h4041_5113);
        wait_idle();

        mem_ready = 0;
        send(7'h13, 0, 0, 1, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("pre_reset_valid", 32'(mem_valid), 1);
        @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        #1;
        reset = 1;
        hold = 0;
        q.delete();
        exp_addr = 0;
        exp_count = 0;
        exp_error = 0;
        @(negedge clk);
        check("post_rst_valid", 32'(mem_valid), 0);
        check("post_rst_addr", mem_address, 0);
        check("post_rst_count", 32'(word_count), 0);
        check("post_rst_ready", 32'(req_ready), 1);
        mem_ready = 1;
        send(7'h13, 0, 0, 1, 0, 0, 5, 1, 32'h0050_0093);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
